key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Front-end conditioner for the board push-buttons (reset, start/pause, display-freeze).
- Per key: synchronises the raw active-low input, debounces it, and produces a clean pressed level, single-cycle press and release pulses, and a press-toggled state bit.
- Sits directly upstream of the stopwatch core, which consumes key_press and key_toggle instead of doing its own hold-time counting.

Parameters:
- NUM_KEYS, 3, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles needed to accept a change (20 ms at 50 MHz); legal range >= 1.
- LONG_PRESS_CYCLES, 50000000, cycles in PRESSED before a long-press event (1 s); used only with the optional feature.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- key_n  input  NUM_KEYS  raw board keys, asynchronous, 0 = pressed.
- key_level  output  NUM_KEYS  debounced level, 1 = pressed.
- key_press  output  NUM_KEYS  one-cycle pulse on accepted press.
- key_release  output  NUM_KEYS  one-cycle pulse on accepted release.
- key_toggle  output  NUM_KEYS  flips on every accepted press.
- key_long  output  NUM_KEYS  one-cycle long-press pulse (only with KEY_LONG_PRESS_EN; otherwise tied 0).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - All outputs 0.
  - Synchroniser flops reset to 1 (released).
  - FSMs in IDLE; counters 0.
  - Reset asserted mid-operation aborts any pending transition; no pulse is emitted on reset release.
- Synchroniser: 2-flop chain per key. The inverted output, p_sync (1 = pressed), drives the FSM.
- Per-key FSM, all channels independent, all outputs registered:
  - IDLE: if p_sync=1, go to PRESS_WAIT with cnt=1; else cnt=0.
  - PRESS_WAIT:
    - p_sync=0: back to IDLE, cnt=0.
    - p_sync=1 and cnt==DEBOUNCE_CYCLES: go to PRESSED, key_level<=1, key_press<=1 for one cycle, key_toggle inverts, cnt=0.
    - Otherwise cnt+1.
  - PRESSED: if p_sync=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: mirror of PRESS_WAIT.
    - p_sync=1: back to PRESSED.
    - cnt reaches DEBOUNCE_CYCLES with p_sync=0: go to IDLE, key_level<=0, key_release<=1 for one cycle.
- Latency: key_n first sampled low at edge t and held gives key_press high in the cycle following edge t+2+DEBOUNCE_CYCLES. Release is symmetric.
- Glitch rejection: any bounce shorter than DEBOUNCE_CYCLES restarts the count and produces no pulse. key_level never changes without a matching pulse.
- Counter width: $clog2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)+1). The counter saturates and never wraps.
- Pulse rules:
  - key_press and key_release are never both high on one channel.
  - Pulses on different channels may coincide.
  - Each pulse lasts exactly one cycle regardless of hold time.
- Holding indefinitely: stays in PRESSED with no further pulses (except key_long when enabled).

Optional Feature:
- Macro KEY_LONG_PRESS_EN.
- Defined:
  - In PRESSED, a separate hold counter increments each cycle.
  - On reaching LONG_PRESS_CYCLES, key_long pulses once. The counter then saturates, so there is at most one key_long per press.
  - The counter is cleared on entry to PRESSED from PRESS_WAIT, not on return from RELEASE_WAIT, so a bounce does not restart the hold time.
- Undefined: no hold counter; key_long is driven constant 0.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_KEYS=3):
- Reset with rst_n=0 while key_n=3'b000 → all outputs 0. Release rst_n with keys still held → no pulse until 2+4 cycles, then key_press=3'b111 for exactly one cycle, key_level=3'b111, key_toggle=3'b111.
- key_n[1] low for 3 cycles, high 1, low 3, high → never accepted; key_press, key_level and key_toggle[1] remain 0.
- key_n[0] clean press held 10 cycles then clean release:
  - key_press[0] one cycle at edge t+7.
  - key_release[0] one cycle 6 cycles after the release edge.
  - key_level[0] high between the two pulses.
- Two separate accepted presses on key_n[2] → key_toggle[2] goes 0→1→0; one key_press[2] pulse each time.
- Mid-hold 2-cycle release glitch on key_n[0] → no key_release[0]; key_level[0] stays 1.
- With KEY_LONG_PRESS_EN, key_n[0] held 40 cycles → exactly one key_long[0] pulse, 20 cycles after key_press[0]. Without the macro → key_long=0 throughout.
- Assert rst_n=0 while a channel is in PRESS_WAIT with cnt=3 → no pulse emitted; FSM back in IDLE after reset.

Source files
------------

// File: rtl/key_conditioner.sv
// Push-button front end: 2-flop synchroniser, debounce FSM, press/release pulses and toggle bit per key.
// Optional long-press pulse per key when KEY_LONG_PRESS_EN is defined; otherwise key_long is tied 0.
module key_conditioner #(
  parameter int NUM_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int MaxCount = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
  localparam int CntW     = $clog2(MaxCount + 1);
  localparam logic [CntW-1:0] DebLimit = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] CntSat   = {CntW{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : gKey
    logic            syncMeta_q, syncOut_q;
    logic            pSync;
    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            toggle_q, toggle_d;

    // Synchroniser idles at 1 so a key held through reset is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        syncMeta_q <= 1'b1;
        syncOut_q  <= 1'b1;
      end else begin
        syncMeta_q <= key_n[g];
        syncOut_q  <= syncMeta_q;
      end
    end

    assign pSync = ~syncOut_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        toggle_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        toggle_q  <= toggle_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      toggle_d  = toggle_q;
      unique case (state_q)
        IDLE: begin
          if (pSync) begin
            state_d = PRESS_WAIT;
            cnt_d   = CntOne;
          end else begin
            cnt_d = '0;
          end
        end
        PRESS_WAIT: begin
          if (!pSync) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DebLimit) begin
            state_d  = PRESSED;
            cnt_d    = '0;
            level_d  = 1'b1;
            press_d  = 1'b1;
            toggle_d = ~toggle_q;
          end else if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntOne;
          end
        end
        PRESSED: begin
          if (!pSync) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CntOne;
          end else begin
            cnt_d = '0;
          end
        end
        RELEASE_WAIT: begin
          if (pSync) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DebLimit) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_toggle[g]  = toggle_q;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CntW-1:0] LongLimit = CntW'(LONG_PRESS_CYCLES);
    localparam logic [CntW-1:0] LongLast  = CntW'(LONG_PRESS_CYCLES - 1);
    logic [CntW-1:0] hold_q, hold_d;
    logic            long_q, long_d;

    // Hold time survives a release bounce; only a fresh debounced press restarts it.
    always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (state_q == PRESS_WAIT && state_d == PRESSED) begin
        hold_d = '0;
      end else if (state_q == PRESSED && hold_q != LongLimit) begin
        hold_d = hold_q + CntOne;
        long_d = (hold_q == LongLast);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    assign key_long[g] = long_q;
`else
    assign key_long[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_KEYS=3.
// Honours KEY_LONG_PRESS_EN when defined at compile time.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic [2:0] key_level, key_press, key_release, key_toggle, key_long;

  int cyc = 0;
  int nVectors = 0;
  int nMiscompares = 0;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] longP;
    logic [2:0] level;
    logic [2:0] toggle;
  } ev_t;

  ev_t        expQ[$];
  ev_t        monEv;
  logic [2:0] expLevel = 3'b000;
  logic [2:0] expToggle = 3'b000;

  key_conditioner #(
    .NUM_KEYS(3),
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_toggle(key_toggle),
    .key_long(key_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s at cyc %0d: got %b, want %b", name, cyc, actual, expected);
    end
  endtask

  // Expected events are queued in chronological order; the level/toggle model follows them.
  task automatic pushEvent(input int offset, input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
    ev_t e;
    expLevel  = (expLevel | p) & ~r;
    expToggle = expToggle ^ p;
    e.cyc    = cyc + offset;
    e.press  = p;
    e.rel    = r;
    e.longP  = l;
    e.level  = expLevel;
    e.toggle = expToggle;
    expQ.push_back(e);
  endtask

  // Called on a falling edge: a change driven here shows up as a pulse 7 cycles later.
  task automatic applyStimulus(input logic [2:0] keyN, input logic [2:0] expPress,
                               input logic [2:0] expRelease, input int holdCycles);
    key_n = keyN;
    if ((expPress | expRelease) != 3'b000) pushEvent(7, expPress, expRelease, 3'b000);
    repeat (holdCycles) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_level"}, key_level, 3'b000);
    checkOutput({tag, "_press"}, key_press, 3'b000);
    checkOutput({tag, "_release"}, key_release, 3'b000);
    checkOutput({tag, "_toggle"}, key_toggle, 3'b000);
    checkOutput({tag, "_long"}, key_long, 3'b000);
  endtask

  task automatic pulseReset(input int lowCycles);
    rst_n = 1'b0;
    key_n = 3'b111;
    expLevel  = 3'b000;
    expToggle = 3'b000;
    repeat (lowCycles) @(negedge clk);
    checkAllZero("inReset");
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (key_press | key_release | key_long) != 3'b000) begin
      if (expQ.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL unexpectedPulse at cyc %0d: got press=%b release=%b long=%b, want no pulse",
                 cyc, key_press, key_release, key_long);
      end else begin
        monEv = expQ.pop_front();
        nVectors++;
        if (cyc != monEv.cyc) begin
          nMiscompares++;
          $display("[TB] FAIL pulseCycle: got cyc %0d, want cyc %0d", cyc, monEv.cyc);
        end
        checkOutput("pulsePress", key_press, monEv.press);
        checkOutput("pulseRelease", key_release, monEv.rel);
        checkOutput("pulseLong", key_long, monEv.longP);
        checkOutput("pulseLevel", key_level, monEv.level);
        checkOutput("pulseToggle", key_toggle, monEv.toggle);
      end
    end else if (expQ.size() != 0 && expQ[0].cyc < cyc) begin
      monEv = expQ.pop_front();
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL missedPulse: got nothing by cyc %0d, want press=%b release=%b long=%b at cyc %0d",
               cyc, monEv.press, monEv.rel, monEv.longP, monEv.cyc);
    end
  end

  initial begin
    @(negedge clk);

    // Keys held through reset: one press on all channels 7 cycles after release.
    key_n = 3'b000;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    pushEvent(7, 3'b111, 3'b000, 3'b000);
    repeat (10) @(negedge clk);
    checkOutput("heldLevel", key_level, 3'b111);
    checkOutput("heldToggle", key_toggle, 3'b111);
    applyStimulus(3'b111, 3'b000, 3'b111, 10);
    checkOutput("allReleasedLevel", key_level, 3'b000);
    pulseReset(2);
    repeat (2) @(negedge clk);

    // Short bounces on key 1 are never accepted.
    applyStimulus(3'b101, 3'b000, 3'b000, 3);
    applyStimulus(3'b111, 3'b000, 3'b000, 1);
    applyStimulus(3'b101, 3'b000, 3'b000, 3);
    applyStimulus(3'b111, 3'b000, 3'b000, 10);
    checkOutput("bounceLevel", key_level, 3'b000);
    checkOutput("bounceToggle", key_toggle, 3'b000);

    // Clean press and release on key 0.
    applyStimulus(3'b110, 3'b001, 3'b000, 10);
    checkOutput("cleanLevelHigh", key_level, 3'b001);
    applyStimulus(3'b111, 3'b000, 3'b001, 10);
    checkOutput("cleanLevelLow", key_level, 3'b000);

    // Two presses on key 2 toggle it back to 0.
    applyStimulus(3'b011, 3'b100, 3'b000, 8);
    checkOutput("toggle2High", key_toggle, 3'b101);
    applyStimulus(3'b111, 3'b000, 3'b100, 8);
    applyStimulus(3'b011, 3'b100, 3'b000, 8);
    applyStimulus(3'b111, 3'b000, 3'b100, 8);
    checkOutput("toggle2Low", key_toggle, 3'b001);

    // Two-cycle release glitch while key 0 is held.
    applyStimulus(3'b110, 3'b001, 3'b000, 9);
    applyStimulus(3'b111, 3'b000, 3'b000, 2);
    applyStimulus(3'b110, 3'b000, 3'b000, 5);
    checkOutput("glitchLevel", key_level, 3'b001);
    checkOutput("glitchToggle", key_toggle, 3'b000);
    applyStimulus(3'b111, 3'b000, 3'b001, 10);
    checkOutput("glitchReleased", key_level, 3'b000);

    // Long hold on key 0.
    applyStimulus(3'b110, 3'b001, 3'b000, 0);
`ifdef KEY_LONG_PRESS_EN
    pushEvent(27, 3'b000, 3'b000, 3'b001);
`endif
    for (int i = 0; i < 4; i++) begin
      repeat (10) @(negedge clk);
`ifndef KEY_LONG_PRESS_EN
      checkOutput("longTiedLow", key_long, 3'b000);
`endif
    end
    checkOutput("longHoldLevel", key_level, 3'b001);
    applyStimulus(3'b111, 3'b000, 3'b001, 10);

    // Reset while key 1 sits in PRESS_WAIT with cnt=3.
    applyStimulus(3'b101, 3'b000, 3'b000, 5);
    pulseReset(2);
    repeat (12) @(negedge clk);
    checkAllZero("afterAbort");
    applyStimulus(3'b101, 3'b010, 3'b000, 10);
    checkOutput("freshPressLevel", key_level, 3'b010);
    applyStimulus(3'b111, 3'b000, 3'b010, 10);

    repeat (5) @(negedge clk);
    nVectors++;
    if (expQ.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL pendingEvents: got %0d left in queue, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
